// File: rtl/fp_add_seq.sv
// Multi-cycle sequencer for the single-precision FP adder datapath: captures an
// operand pair, steps select/align/add/normalize/round, and hands off the result.
module fp_add_seq #(
   parameter int ALIGN_MAX = 27,
   parameter int NORM_MAX  = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] num_a,
   input  logic [31:0] num_b,
   output logic [31:0] sel_num_a,
   output logic [31:0] sel_num_b,
   output logic        sel_en,
   input  logic [1:0]  edata,
   output logic        align_en,
   output logic [7:0]  shift_amt,
   output logic        swap,
   output logic        sub_op,
   output logic        add_en,
   output logic        norm_en,
   input  logic        norm_done,
   output logic        rnd_en,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  op_class,
   output logic        special,
   output logic        err
);

   localparam int CNT_W = $clog2(NORM_MAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      ALIGN,
      ADD,
      NORM,
      ROUND,
      DONE
   } state_t;

   state_t             state_reg;
   logic [CNT_W-1:0]   norm_cnt_reg;
   logic [CNT_W-1:0]   norm_cnt_next;

   logic [7:0]         ea_raw;
   logic [7:0]         eb_raw;
   logic [7:0]         ea_eff;
   logic [7:0]         eb_eff;
   logic [7:0]         exp_diff;
   logic [7:0]         shift_next;
   logic               swap_next;
   logic               special_next;

   // Zero exponents (denormals) align as if their exponent were 1.
   assign ea_raw   = sel_num_a[30:23];
   assign eb_raw   = sel_num_b[30:23];
   assign ea_eff   = (ea_raw == 8'd0) ? 8'd1 : ea_raw;
   assign eb_eff   = (eb_raw == 8'd0) ? 8'd1 : eb_raw;
   assign exp_diff = (eb_eff > ea_eff) ? (eb_eff - ea_eff) : (ea_eff - eb_eff);

   assign shift_next   = (exp_diff > 8'(ALIGN_MAX)) ? 8'(ALIGN_MAX) : exp_diff;
   assign swap_next    = (eb_eff > ea_eff) ||
                         ((eb_eff == ea_eff) && (sel_num_b[22:0] > sel_num_a[22:0]));
   assign special_next = (ea_raw == 8'hFF) || (eb_raw == 8'hFF);

   assign norm_cnt_next = norm_cnt_reg + 1'b1;

   // Handshake flags and strobes are pure state decodes, so an async reset drops them at once.
   assign in_ready  = (state_reg == IDLE);
   assign sel_en    = (state_reg == SELECT);
   assign align_en  = (state_reg == ALIGN);
   assign add_en    = (state_reg == ADD);
   assign norm_en   = (state_reg == NORM);
   assign rnd_en    = (state_reg == ROUND);
   assign out_valid = (state_reg == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         norm_cnt_reg <= '0;
         sel_num_a    <= '0;
         sel_num_b    <= '0;
         shift_amt    <= '0;
         swap         <= 1'b0;
         sub_op       <= 1'b0;
         op_class     <= '0;
         special      <= 1'b0;
         err          <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  sel_num_a    <= num_a;
                  sel_num_b    <= num_b;
                  special      <= 1'b0;
                  err          <= 1'b0;
                  norm_cnt_reg <= '0;
                  state_reg    <= SELECT;
               end
            end
            SELECT: begin
               op_class  <= edata;
               swap      <= swap_next;
               shift_amt <= shift_next;
               sub_op    <= sel_num_a[31] ^ sel_num_b[31];
               if (special_next) begin
                  special   <= 1'b1;
                  state_reg <= DONE;
               end else if (edata == 2'b11) begin
                  err       <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  state_reg <= ALIGN;
               end
            end
            ALIGN: state_reg <= ADD;
            ADD: begin
               norm_cnt_reg <= '0;
               state_reg    <= NORM;
            end
            NORM: begin
               norm_cnt_reg <= norm_cnt_next;
               // A late norm_done still wins over the timeout in the same cycle.
               if (norm_done) begin
                  state_reg <= ROUND;
               end else if (norm_cnt_next == CNT_W'(NORM_MAX)) begin
                  err       <= 1'b1;
                  state_reg <= DONE;
               end
            end
            ROUND: state_reg <= DONE;
            DONE: begin
               if (out_ready) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq: latency, control values, bypass, timeout,
// backpressure and asynchronous reset.
module tb_fp_add_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] num_a;
   logic [31:0] num_b;
   logic [31:0] sel_num_a;
   logic [31:0] sel_num_b;
   logic        sel_en;
   logic [1:0]  edata;
   logic        align_en;
   logic [7:0]  shift_amt;
   logic        swap;
   logic        sub_op;
   logic        add_en;
   logic        norm_en;
   logic        norm_done;
   logic        rnd_en;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  op_class;
   logic        special;
   logic        err;

   int vectors = 0;
   int miscompares = 0;

   int cyc;
   int ncyc;
   bit s_al, s_ad, s_no, s_rn;

   fp_add_seq #(.ALIGN_MAX(27), .NORM_MAX(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .num_a(num_a), .num_b(num_b),
      .sel_num_a(sel_num_a), .sel_num_b(sel_num_b),
      .sel_en(sel_en), .edata(edata),
      .align_en(align_en), .shift_amt(shift_amt),
      .swap(swap), .sub_op(sub_op),
      .add_en(add_en), .norm_en(norm_en), .norm_done(norm_done),
      .rnd_en(rnd_en), .out_valid(out_valid), .out_ready(out_ready),
      .op_class(op_class), .special(special), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one operand pair while idle; returns in cycle 1 (SELECT).
   task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [1:0] cls);
      num_a    = a;
      num_b    = b;
      edata    = cls;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   // Runs from cycle 1 until out_valid, raising norm_done on NORM cycle done_at.
   task automatic run(input int done_at, output int c, output int nc,
                      output bit al, output bit ad, output bit no, output bit rn);
      int nstrobe;
      c = 1; nc = 0; al = 0; ad = 0; no = 0; rn = 0;
      while (!out_valid && c < 200) begin
         nstrobe = int'(sel_en) + int'(align_en) + int'(add_en) + int'(rnd_en);
         if (nstrobe > 1) check("strobe_exclusive", nstrobe, 1);
         if (align_en) al = 1;
         if (add_en)   ad = 1;
         if (norm_en) begin
            no = 1;
            nc++;
         end
         rn = rn | rnd_en;
         norm_done = norm_en && (nc >= done_at);
         step();
         c++;
      end
      norm_done = 1'b0;
      check("done_within_budget", out_valid, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; num_a = '0; num_b = '0;
      edata = 2'b00; norm_done = 1'b0; out_ready = 1'b0;
      #12;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sel_en", sel_en, 1'b0);
      check("rst_sel_num_a", sel_num_a, 32'h0);
      check("rst_flags", {special, err, swap, sub_op}, 4'b0);
      rst_n = 1'b1;
      step();

      // Normal add 1.0 + 2.0, with backpressure and a rejected second offer
      offer(32'h3F800000, 32'h40000000, 2'b01);
      check("n_sel_en", sel_en, 1'b1);
      check("n_in_ready_busy", in_ready, 1'b0);
      check("n_sel_num_b", sel_num_b, 32'h40000000);
      run(1, cyc, ncyc, s_al, s_ad, s_no, s_rn);
      check("n_latency", cyc, 6);
      check("n_stages", {s_al, s_ad, s_no, s_rn}, 4'b1111);
      check("n_op_class", op_class, 2'b01);
      check("n_swap", swap, 1'b1);
      check("n_shift", shift_amt, 8'd1);
      check("n_sub_op", sub_op, 1'b0);
      check("n_special_err", {special, err}, 2'b00);
      num_a = 32'h12345678; num_b = 32'h9ABCDEF0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_in_ready", in_ready, 1'b0);
         check("bp_controls", {op_class, swap, sub_op, shift_amt}, {2'b01, 1'b1, 1'b0, 8'd1});
         check("bp_sel_num_a", sel_num_a, 32'h3F800000);
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("hs_out_valid_drop", out_valid, 1'b0);
      check("hs_in_ready_rise", in_ready, 1'b1);
      check("hs_second_rejected", sel_num_a, 32'h3F800000);

      // Denormal vs normal: exponent gap 126 saturates to 27
      offer(32'h00000001, 32'h3F800000, 2'b10);
      run(1, cyc, ncyc, s_al, s_ad, s_no, s_rn);
      check("m_latency", cyc, 6);
      check("m_op_class", op_class, 2'b10);
      check("m_swap", swap, 1'b1);
      check("m_shift_sat", shift_amt, 8'd27);
      check("m_sub_op", sub_op, 1'b0);
      step();
      check("m_in_ready", in_ready, 1'b1);

      // Infinity operand bypasses the datapath
      offer(32'h7F800000, 32'h3F800000, 2'b01);
      run(1, cyc, ncyc, s_al, s_ad, s_no, s_rn);
      check("s_latency", cyc, 2);
      check("s_no_stages", {s_al, s_ad, s_no, s_rn}, 4'b0000);
      check("s_special_err", {special, err}, 2'b10);
      check("s_swap_shift", {swap, shift_amt}, {1'b0, 8'd27});
      step();

      // Illegal class, equal magnitudes with opposite signs
      offer(32'h3F800000, 32'hBF800000, 2'b11);
      run(1, cyc, ncyc, s_al, s_ad, s_no, s_rn);
      check("i_latency", cyc, 2);
      check("i_no_stages", {s_al, s_ad, s_no, s_rn}, 4'b0000);
      check("i_special_err", {special, err}, 2'b01);
      check("i_op_class", op_class, 2'b11);
      check("i_controls", {swap, sub_op, shift_amt}, {1'b0, 1'b1, 8'd0});
      step();

      // Normalize timeout: 32 NORM cycles, no ROUND
      offer(32'h40400000, 32'h3F800000, 2'b01);
      run(1000, cyc, ncyc, s_al, s_ad, s_no, s_rn);
      check("t_norm_cycles", ncyc, 32);
      check("t_latency", cyc, 36);
      check("t_no_round", s_rn, 1'b0);
      check("t_special_err", {special, err}, 2'b01);
      check("t_swap_shift", {swap, shift_amt}, {1'b0, 8'd1});
      step();

      // norm_done on the last allowed NORM cycle beats the timeout
      offer(32'h40400000, 32'h3F800000, 2'b01);
      run(32, cyc, ncyc, s_al, s_ad, s_no, s_rn);
      check("p_norm_cycles", ncyc, 32);
      check("p_latency", cyc, 37);
      check("p_round_seen", s_rn, 1'b1);
      check("p_err", err, 1'b0);
      step();

      // Async reset in the middle of a NORM cycle
      offer(32'hC0000000, 32'h3F800000, 2'b01);
      step(); step(); step();
      check("r_in_norm", norm_en, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("r_norm_en_drop", norm_en, 1'b0);
      check("r_in_ready", in_ready, 1'b1);
      check("r_out_valid", out_valid, 1'b0);
      check("r_operands", {sel_num_a, sel_num_b}, 64'h0);
      check("r_controls", {op_class, swap, sub_op, shift_amt}, 12'h0);
      #2;
      rst_n = 1'b1;
      step();
      check("r_idle_after", {in_ready, out_valid, sel_en}, 3'b100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
